// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch unit
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  fault;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO of fetch entries with flush and count output
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W:0]         count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: it is only observed while count_q != 0.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : sequential PC fetch from a 1-cycle ROM, buffered to decode
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  rom_illegal_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_fault_o
);

    import fetch_pkg::*;

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic                  req_v_q, req_v_d;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      occupancy;
    logic                  deq_hs, pop, enq, fault_enq, issue;
    fetch_entry_t          head, enq_entry, hold_q, out_entry;

    assign rom_addr_o   = redirect_valid_i ? redirect_pc_i : pc_q;
    assign inst_valid_o = (count != '0);
    assign deq_hs       = inst_valid_o & inst_ready_i;
    assign pop          = deq_hs & ~redirect_valid_i;
    assign enq          = req_v_q & ~redirect_valid_i;
    assign fault_enq    = enq & rom_illegal_i;

    // Occupancy counts the response already in flight so the FIFO can never overflow.
    assign occupancy = count + CNT_W'(req_v_q) - CNT_W'(deq_hs);
    assign issue     = redirect_valid_i
                     | ((state_q == RUN) & (occupancy < DEPTH_C) & ~fault_enq);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_v_d = issue;
        if (issue) pc_d = rom_addr_o + ADDR_WIDTH'(INST_BYTES);
        if (redirect_valid_i)    state_d = RUN;
        else if (fault_enq)      state_d = HALT;
        else if (state_q == BOOT) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_v_q <= req_v_d;
            if (issue) req_pc_q <= rom_addr_o;
        end
    end

    always_comb begin
        enq_entry       = '0;
        enq_entry.inst  = rom_data_i;
        enq_entry.pc    = req_pc_q;
        enq_entry.fault = rom_illegal_i;
    end

    fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid_i),
        .push_i      (enq),
        .push_data_i (enq_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    // Shadow of the last visible head so outputs hold steady while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            hold_q <= '0;
        else if (inst_valid_o) hold_q <= head;
    end

    assign out_entry    = inst_valid_o ? head : hold_q;
    assign inst_o       = out_entry.inst;
    assign inst_pc_o    = out_entry.pc;
    assign inst_fault_o = out_entry.fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : directed + randomized bench with a PC-stream reference model
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;

    localparam int          AW     = 64;
    localparam int          DW     = 32;
    localparam logic [63:0] RST_PC = 64'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i;
    logic          rom_illegal_i;
    logic          redirect_valid_i;
    logic [AW-1:0] redirect_pc_i;
    logic          inst_valid_o;
    logic          inst_ready_i;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
    logic          inst_fault_o;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [63:0] exp_pc;
    bit          halted;
    int          gap;

    instr_fetch #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .RESET_PC         (RST_PC),
        .FIFO_DEPTH       (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rom_addr_o       (rom_addr_o),
        .rom_data_i       (rom_data_i),
        .rom_illegal_i    (rom_illegal_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_fault_o     (inst_fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h0000_0013;
        if (a == 64'h4) return 32'h0010_0093;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    // ROM: one-cycle latency, misaligned addresses flag an illegal access.
    always @(posedge clk) begin
        rom_data_i    <= rom_word(rom_addr_o);
        rom_illegal_i <= (rom_addr_o[1:0] != 2'b00);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after negedge, then check against the PC-stream model.
    task automatic cycle(input bit rdy, input bit redir, input logic [63:0] tgt);
        @(negedge clk);
        inst_ready_i     = rdy;
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        #1;
        if (redir) chk("redir_addr", rom_addr_o, tgt);
        if (inst_valid_o) begin
            gap = 0;
            if (halted) chk("halt_quiet", {63'h0, inst_valid_o}, 64'h0);
            else if (rdy && !redir) begin
                chk("pc", inst_pc_o, exp_pc);
                chk("fault", {63'h0, inst_fault_o}, {63'h0, exp_pc[1:0] != 2'b00});
                if (exp_pc[1:0] == 2'b00) chk("inst", {32'h0, inst_o}, {32'h0, rom_word(exp_pc)});
                else halted = 1'b1;
                exp_pc = exp_pc + 64'd4;
            end
        end else if (!halted) begin
            gap++;
            chk("gap", {63'h0, gap > 3}, 64'h0);
        end
        if (redir) begin
            exp_pc = tgt;
            halted = 1'b0;
            gap    = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        inst_ready_i     = 1'b1;
        #1;
        chk("rst_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("rst_inst",  {32'h0, inst_o}, 64'h0);
        chk("rst_pc",    inst_pc_o, 64'h0);
        chk("rst_fault", {63'h0, inst_fault_o}, 64'h0);
        chk("rst_addr",  rom_addr_o, RST_PC);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = RST_PC;
        halted = 1'b0;
        gap    = 0;
    endtask

    task automatic startup();
        #1 chk("boot_addr", rom_addr_o, RST_PC);
        cycle(1, 0, 0); chk("s1_addr", rom_addr_o, RST_PC);        chk("s1_valid", {63'h0, inst_valid_o}, 64'h0);
        cycle(1, 0, 0); chk("s2_addr", rom_addr_o, RST_PC + 4);    chk("s2_valid", {63'h0, inst_valid_o}, 64'h0);
        cycle(1, 0, 0); chk("s3_addr", rom_addr_o, RST_PC + 8);    chk("s3_valid", {63'h0, inst_valid_o}, 64'h1);
    endtask

    task automatic redirect_check(input logic [63:0] tgt);
        cycle(1, 1, tgt);
        cycle(1, 0, 0);
        chk("redir_flush", {63'h0, inst_valid_o}, 64'h0);
        chk("redir_next_addr", rom_addr_o, tgt + 64'd4);
        cycle(1, 0, 0);
        chk("redir_lat", {63'h0, inst_valid_o}, 64'h1);
        chk("redir_pc0", inst_pc_o, tgt);
        cycle(1, 0, 0);
        chk("redir_pc1", inst_pc_o, tgt + 64'd4);
    endtask

    initial begin
        logic [63:0] frozen;
        inst_ready_i     = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        exp_pc           = RST_PC;
        halted           = 1'b0;
        gap              = 0;

        do_reset();
        startup();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0);
            chk("stream_valid", {63'h0, inst_valid_o}, 64'h1);
        end

        // Backpressure: address freezes with exactly two entries buffered.
        cycle(0, 0, 0);
        frozen = rom_addr_o;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            chk("stall_addr", rom_addr_o, frozen);
            chk("stall_depth", rom_addr_o - inst_pc_o, 64'd8);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);

        // Redirect while full, then while a request is in flight.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        redirect_check(64'h100);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        redirect_check(64'h300);

        // Misaligned target: fault entry, halt, then resume.
        cycle(1, 1, 64'h102);
        cycle(1, 0, 0);
        chk("mis_flush", {63'h0, inst_valid_o}, 64'h0);
        cycle(1, 0, 0);
        chk("mis_valid", {63'h0, inst_valid_o}, 64'h1);
        chk("mis_pc", inst_pc_o, 64'h102);
        chk("mis_fault", {63'h0, inst_fault_o}, 64'h1);
        frozen = rom_addr_o;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0);
            chk("halt_idle", {63'h0, inst_valid_o}, 64'h0);
            chk("halt_addr", rom_addr_o, frozen);
        end
        redirect_check(64'h200);

        // Address wrap at the top of the space.
        redirect_check(64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);

        // Mid-stream reset with a request in flight.
        do_reset();
        startup();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          rd;
            bit          rv;
            logic [63:0] t;
            rd = ($urandom_range(3) != 0);
            rv = halted ? ($urandom_range(4) == 0) : ($urandom_range(29) == 0);
            t  = {$urandom(), $urandom()};
            if ($urandom_range(1) == 0) t[63:16] = '0;
            if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3));
            else                        t[1:0] = 2'b00;
            if ($urandom_range(499) == 0) do_reset();
            else                          cycle(rd, rv, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
